uart_receiver: RTL and testbench



---
 rtl/uart_receiver_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_receiver.sv | 175 +++++++++++++++++
 tb/tb_uart_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// the oversampling terminal counts for 8x and 16x operation.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } rx_state_t;

    localparam int OSR8  = 8;
    localparam int OSR16 = 16;

    localparam logic [3:0] OSR8_LAST   = 4'(OSR8 - 1);
    localparam logic [3:0] OSR16_LAST  = 4'(OSR16 - 1);
    localparam logic [3:0] HALF8_LAST  = 4'(OSR8 / 2 - 1);
    localparam logic [3:0] HALF16_LAST = 4'(OSR16 / 2 - 1);

    function automatic logic [3:0] osr_last(input logic bsel);
        return bsel ? OSR8_LAST : OSR16_LAST;
    endfunction

    function automatic logic [3:0] half_last(input logic bsel);
        return bsel ? HALF8_LAST : HALF16_LAST;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous serial line; resets to
// the idle (high) level so a reset never looks like a start bit.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start qualification, mid-bit sampling of data/parity/stop,
// and a one-entry holding register with parity, framing and overrun status.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              apb_en,
    input  logic              apb_bsel,
    input  logic              apb_pen,
    input  logic              apb_eps,
    input  logic              brg_rx_shift,
    input  logic              uart_rxd,
    input  logic              rx_rd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_pe,
    output logic              rx_fe,
    output logic              rx_oe,
    output logic              rx_busy
);

    localparam logic [2:0] BCNT_LAST = 3'(DATA_W - 1);

    logic              rxd_s;
    rx_state_t         state, state_nxt;
    logic [3:0]        tcnt, tcnt_nxt;
    logic [2:0]        bcnt, bcnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              pe_cur, pe_cur_nxt;
    logic              load, load_fe;
    logic [3:0]        osr_l, half_l;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (pclk),
        .rst (prst),
        .d   (uart_rxd),
        .q   (rxd_s)
    );

    assign osr_l   = osr_last(apb_bsel);
    assign half_l  = half_last(apb_bsel);
    assign rx_busy = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = tcnt;
        bcnt_nxt   = bcnt;
        shift_nxt  = shift;
        pe_cur_nxt = pe_cur;
        load       = 1'b0;
        load_fe    = 1'b0;
        if (!apb_en) begin
            state_nxt = ST_IDLE;
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (brg_rx_shift && !rxd_s) begin
                        state_nxt = ST_START;
                        tcnt_nxt  = '0;
                    end
                end
                ST_START: begin
                    if (brg_rx_shift) begin
                        if (tcnt == half_l) begin
                            tcnt_nxt = '0;
                            if (!rxd_s) begin
                                state_nxt  = ST_DATA;
                                bcnt_nxt   = '0;
                                pe_cur_nxt = 1'b0;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            tcnt_nxt = tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (brg_rx_shift) begin
                        if (tcnt == osr_l) begin
                            tcnt_nxt  = '0;
                            shift_nxt = {rxd_s, shift[DATA_W-1:1]};
                            if (bcnt == BCNT_LAST) begin
                                state_nxt = apb_pen ? ST_PARITY : ST_STOP;
                            end else begin
                                bcnt_nxt = bcnt + 3'd1;
                            end
                        end else begin
                            tcnt_nxt = tcnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (brg_rx_shift) begin
                        if (tcnt == osr_l) begin
                            tcnt_nxt   = '0;
                            pe_cur_nxt = (((^shift) ^ rxd_s) != !apb_eps);
                            state_nxt  = ST_STOP;
                        end else begin
                            tcnt_nxt = tcnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (brg_rx_shift) begin
                        if (tcnt == osr_l) begin
                            tcnt_nxt  = '0;
                            load      = 1'b1;
                            load_fe   = !rxd_s;
                            state_nxt = rxd_s ? ST_IDLE : ST_RECOVER;
                        end else begin
                            tcnt_nxt = tcnt + 4'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    // A held-low line (break) must not look like a fresh start bit.
                    if (rxd_s) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state  <= ST_IDLE;
            tcnt   <= '0;
            bcnt   <= '0;
            shift  <= '0;
            pe_cur <= 1'b0;
        end else begin
            state  <= state_nxt;
            tcnt   <= tcnt_nxt;
            bcnt   <= bcnt_nxt;
            shift  <= shift_nxt;
            pe_cur <= pe_cur_nxt;
        end
    end

    // A pop coinciding with a load lets the load win; otherwise a full register drops the frame.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_pe    <= 1'b0;
            rx_fe    <= 1'b0;
            rx_oe    <= 1'b0;
        end else if (load) begin
            if (rx_valid && !rx_rd) begin
                rx_oe <= 1'b1;
            end else begin
                rx_data  <= shift;
                rx_pe    <= pe_cur;
                rx_fe    <= load_fe;
                rx_valid <= 1'b1;
            end
        end else if (rx_rd && rx_valid) begin
            rx_valid <= 1'b0;
            rx_oe    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written
// sequences for glitch, break, overrun, coincident pop, disable and reset.
module tb_uart_receiver;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       apb_en = 1'b0;
    logic       apb_bsel = 1'b0;
    logic       apb_pen = 1'b0;
    logic       apb_eps = 1'b0;
    logic       brg_rx_shift = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_pe, rx_fe, rx_oe, rx_busy;

    uart_receiver dut (
        .pclk         (pclk),
        .prst         (prst),
        .apb_en       (apb_en),
        .apb_bsel     (apb_bsel),
        .apb_pen      (apb_pen),
        .apb_eps      (apb_eps),
        .brg_rx_shift (brg_rx_shift),
        .uart_rxd     (uart_rxd),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pe        (rx_pe),
        .rx_fe        (rx_fe),
        .rx_oe        (rx_oe),
        .rx_busy      (rx_busy)
    );

    always #5 pclk = ~pclk;

    // Baud generator model: one-pclk tick every 4 pclk.
    int tdiv = 0;
    always @(negedge pclk) begin
        tdiv = (tdiv + 1) % 4;
        brg_rx_shift = (tdiv == 0);
    end

    typedef struct {
        logic       osr8;
        logic       pen;
        logic       eps;
        logic       pbit;
        logic       stop;
        logic [7:0] data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   rises = 0;
    int   late = 0;
    time  rise_t = 0;
    time  start_t = 0;
    event start_ev;
    logic vq = 1'b0;
    logic tk;

    // Every rx_valid rise must follow a tick cycle (load is one pclk after the stop sample).
    always @(posedge pclk) begin
        tk = brg_rx_shift;
        #1;
        if (rx_valid === 1'b1 && vq !== 1'b1) begin
            rises++;
            rise_t = $time - 1;
            if (tk !== 1'b1) late++;
        end
        vq = rx_valid;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge pclk); while (brg_rx_shift !== 1'b1);
    endtask

    task automatic send_bit(input logic b, input int osr);
        uart_rxd = b;
        repeat (osr) wait_tick();
        @(negedge pclk);
    endtask

    task automatic applyStimulus(input vec_t v, input bit push);
        int   osr;
        exp_t e;
        osr = v.osr8 ? 8 : 16;
        apb_bsel = v.osr8;
        apb_pen  = v.pen;
        apb_eps  = v.eps;
        if (push) begin
            e.data = v.data;
            e.pe   = v.exp_pe;
            e.fe   = v.exp_fe;
            sb.push_back(e);
        end
        wait_tick();
        @(negedge pclk);
        start_t = $time;
        ->start_ev;
        send_bit(1'b0, osr);
        for (int i = 0; i < 8; i++) send_bit(v.data[i], osr);
        if (v.pen) send_bit(v.pbit, osr);
        send_bit(v.stop, osr);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        checkOutput(name, rx_valid, 1);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got output, required empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_data"}, rx_data, e.data);
            checkOutput({name, "_pe"}, rx_pe, e.pe);
            checkOutput({name, "_fe"}, rx_fe, e.fe);
        end
    endtask

    task automatic pop_rd();
        @(negedge pclk);
        rx_rd = 1'b1;
        @(negedge pclk);
        rx_rd = 1'b0;
    endtask

    function automatic vec_t mk(input logic osr8, input logic pen, input logic eps,
                                input logic pbit, input logic stop, input logic [7:0] data,
                                input logic exp_pe, input logic exp_fe);
        vec_t v;
        v.osr8 = osr8; v.pen = pen; v.eps = eps; v.pbit = pbit; v.stop = stop;
        v.data = data; v.exp_pe = exp_pe; v.exp_fe = exp_fe;
        return v;
    endfunction

    vec_t vecs[8];
    int   r0;
    time  delta;

    initial begin
        vecs[0] = mk(0, 0, 0, 0, 1, 8'hA5, 0, 0);
        vecs[1] = mk(1, 1, 1, 1, 1, 8'h3C, 1, 0);
        vecs[2] = mk(1, 1, 1, 0, 1, 8'h3C, 0, 0);
        vecs[3] = mk(1, 1, 0, 1, 1, 8'h3C, 0, 0);
        vecs[4] = mk(0, 1, 0, 1, 1, 8'h01, 1, 0);
        vecs[5] = mk(1, 0, 0, 0, 0, 8'h00, 0, 1);
        vecs[6] = mk(0, 0, 0, 0, 1, 8'hFF, 0, 0);
        vecs[7] = mk(1, 1, 1, 0, 1, 8'h81, 0, 0);

        repeat (4) @(negedge pclk);
        checkOutput("reset_data", rx_data, 0);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_pe", rx_pe, 0);
        checkOutput("reset_fe", rx_fe, 0);
        checkOutput("reset_oe", rx_oe, 0);
        checkOutput("reset_busy", rx_busy, 0);
        prst = 1'b0;
        apb_en = 1'b1;
        repeat (8) @(negedge pclk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b1);
            wait_valid($sformatf("vec%0d_valid", i));
            pop_check($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_oe", i), rx_oe, 0);
            pop_rd();
            checkOutput($sformatf("vec%0d_popped", i), rx_valid, 0);
        end
        checkOutput("load_latency", late, 0);
        checkOutput("table_loads", rises, 8);

        // Short low glitch at 16x is rejected at the start-bit centre.
        $display("[TB] glitch rejection");
        r0 = rises;
        apb_bsel = 1'b0;
        apb_pen = 1'b0;
        wait_tick();
        @(negedge pclk);
        uart_rxd = 1'b0;
        repeat (3) wait_tick();
        @(negedge pclk);
        uart_rxd = 1'b1;
        checkOutput("glitch_busy_start", rx_busy, 1);
        repeat (12) wait_tick();
        @(negedge pclk);
        checkOutput("glitch_busy_idle", rx_busy, 0);
        checkOutput("glitch_valid", rx_valid, 0);
        checkOutput("glitch_loads", rises, r0);

        // Framing error followed by a line held low for three frame times.
        $display("[TB] break handling");
        r0 = rises;
        apb_bsel = 1'b1;
        sb.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b1});
        wait_tick();
        @(negedge pclk);
        repeat (10) send_bit(1'b0, 8);
        repeat (30 * 8) wait_tick();
        @(negedge pclk);
        checkOutput("break_loads", rises, r0 + 1);
        checkOutput("break_valid", rx_valid, 1);
        checkOutput("break_busy", rx_busy, 1);
        pop_check("break");
        pop_rd();
        checkOutput("break_popped", rx_valid, 0);
        uart_rxd = 1'b1;
        repeat (4) wait_tick();
        @(negedge pclk);
        checkOutput("break_recovered", rx_busy, 0);
        applyStimulus(mk(1, 0, 0, 0, 1, 8'h5A, 0, 0), 1'b1);
        wait_valid("after_break_valid");
        pop_check("after_break");
        pop_rd();

        // Overrun: second frame is dropped and the first one is kept.
        $display("[TB] overrun");
        applyStimulus(mk(0, 0, 0, 0, 1, 8'h11, 0, 0), 1'b1);
        applyStimulus(mk(0, 0, 0, 0, 1, 8'h22, 0, 0), 1'b0);
        wait_valid("ovr_valid");
        checkOutput("ovr_oe_set", rx_oe, 1);
        pop_check("ovr");
        pop_rd();
        checkOutput("ovr_popped", rx_valid, 0);
        checkOutput("ovr_oe_clear", rx_oe, 0);

        // Pop landing exactly on the load edge: load wins, no overrun.
        $display("[TB] coincident load and pop");
        applyStimulus(mk(0, 0, 0, 0, 1, 8'h33, 0, 0), 1'b1);
        wait_valid("coin_first_valid");
        pop_check("coin_first");
        delta = rise_t - start_t;
        sb.push_back('{data: 8'h44, pe: 1'b0, fe: 1'b0});
        fork
            applyStimulus(mk(0, 0, 0, 0, 1, 8'h44, 0, 0), 1'b0);
            begin
                @(start_ev);
                #(delta - 5);
                rx_rd = 1'b1;
                #10;
                rx_rd = 1'b0;
            end
        join
        checkOutput("coin_valid", rx_valid, 1);
        checkOutput("coin_oe", rx_oe, 0);
        pop_check("coin_second");
        pop_rd();

        // Disable mid-DATA drops the frame.
        $display("[TB] disable and reset mid-frame");
        r0 = rises;
        apb_bsel = 1'b0;
        wait_tick();
        @(negedge pclk);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        apb_en = 1'b0;
        @(negedge pclk);
        checkOutput("dis_busy", rx_busy, 0);
        repeat (5) send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        apb_en = 1'b1;
        repeat (4) wait_tick();
        @(negedge pclk);
        checkOutput("dis_valid", rx_valid, 0);
        checkOutput("dis_loads", rises, r0);

        // Reset while sampling the stop bit.
        wait_tick();
        @(negedge pclk);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(i[0], 16);
        uart_rxd = 1'b1;
        repeat (4) wait_tick();
        @(negedge pclk);
        checkOutput("rst_pre_busy", rx_busy, 1);
        prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        checkOutput("rst_busy", rx_busy, 0);
        checkOutput("rst_valid", rx_valid, 0);
        checkOutput("rst_data", rx_data, 0);
        checkOutput("rst_oe", rx_oe, 0);
        repeat (20) wait_tick();
        @(negedge pclk);
        checkOutput("rst_no_load", rx_valid, 0);
        checkOutput("rst_loads", rises, r0);
        checkOutput("rst_idle", rx_busy, 0);
        checkOutput("final_latency", late, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
